// File: rtl/t1c_mem_loader.sv
// Streams 32-bit words into t1c core memory via the external write port while holding the core in reset.
// Optional trailer checksum verification enabled by defining T1C_LOADER_CHECKSUM_EN.
module t1c_mem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_DataAdr,
  output logic [31:0] Ext_WriteData,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef T1C_LOADER_CHECKSUM_EN
    CHECK,
`endif
    RELEASE,
    RUN,
    ERROR
  } state_e;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] len_q,   len_d;
  logic        wr_q,    wr_d;
  logic [31:0] wadr_q,  wadr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q,   err_d;
`ifdef T1C_LOADER_CHECKSUM_EN
  logic [31:0] sum_q,   sum_d;
`endif

  // All handshake-facing outputs are pure decodes of registered state.
`ifdef T1C_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == LOAD) || (state_q == CHECK);
  assign busy     = (state_q == LOAD) || (state_q == CHECK) || (state_q == RELEASE);
`else
  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD) || (state_q == RELEASE);
`endif
  assign done          = (state_q == RELEASE);
  assign cpu_reset     = (state_q != RUN);
  assign err           = err_q;
  assign Ext_MemWrite  = wr_q;
  assign Ext_DataAdr   = wadr_q;
  assign Ext_WriteData = wdata_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    len_d   = len_q;
    wr_d    = 1'b0;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef T1C_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          err_d   = 1'b0;
          addr_d  = BASE_ADDR;
          count_d = '0;
          len_d   = len;
`ifdef T1C_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
          if ({1'b0, len} > DEPTH_L) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (len == '0) begin
            state_d = RELEASE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_d    = 1'b1;
          wadr_d  = addr_q;
          wdata_d = in_data;
          addr_d  = addr_q + 32'd4;
          count_d = count_q + 16'd1;
`ifdef T1C_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
          if (count_q + 16'd1 == len_q) state_d = CHECK;
`else
          if (count_q + 16'd1 == len_q) state_d = RELEASE;
`endif
        end
      end
`ifdef T1C_LOADER_CHECKSUM_EN
      // Trailer word is compared only, never written to memory.
      CHECK: begin
        if (in_valid) begin
          if (in_data == sum_q) begin
            state_d = RELEASE;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      RELEASE: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef T1C_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      wadr_q  <= wadr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef T1C_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_t1c_mem_loader.sv
// Self-checking bench for t1c_mem_loader: vector table, directed corner sequences and randomized sessions.
// Two instances share stimulus; the second uses a base address that wraps past 2^32.
module tb_t1c_mem_loader;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] BW = 32'hFFFF_FFFC;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, mw, cpu_reset, busy, done, err;
  logic [31:0] adr, wd;
  logic        in_ready_w, mw_w, cpu_reset_w, busy_w, done_w, err_w;
  logic [31:0] adr_w, wd_w;

  int unsigned total = 0, bad = 0;
  logic [31:0] words[$];
  bit          vpat[$];

  always #5 clk = ~clk;

  t1c_mem_loader #(.BASE_ADDR(B0), .DEPTH_WORDS(64)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .Ext_MemWrite(mw), .Ext_DataAdr(adr), .Ext_WriteData(wd),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err));

  t1c_mem_loader #(.BASE_ADDR(BW), .DEPTH_WORDS(64)) dut_w (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w), .Ext_MemWrite(mw_w), .Ext_DataAdr(adr_w), .Ext_WriteData(wd_w),
    .cpu_reset(cpu_reset_w), .busy(busy_w), .done(done_w), .err(err_w));

  typedef struct {
    bit          st;
    logic [15:0] ln;
    bit          v;
    logic [31:0] d;
    bit          mw;
    bit          hold;
    logic [31:0] off;
    logic [31:0] wdat;
    logic [4:0]  ctl;   // {in_ready, done, cpu_reset, busy, err}
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] e);
    chk({tag, ".ctl"}, {22'b0, in_ready, done, cpu_reset, busy, err,
                        in_ready_w, done_w, cpu_reset_w, busy_w, err_w}, {22'b0, e, e});
  endtask

  // hold=1 checks the port still shows the last write while the strobe is low.
  task automatic chk_wr(input string tag, input bit exp_mw, input bit hold,
                        input logic [31:0] off, input logic [31:0] d);
    chk({tag, ".mw"}, {30'b0, mw, mw_w}, {30'b0, exp_mw, exp_mw});
    if (exp_mw || hold) begin
      chk({tag, ".adr"},   adr,   B0 + off);
      chk({tag, ".adr_w"}, adr_w, BW + off);
      chk({tag, ".wd"},    wd,    d);
      chk({tag, ".wd_w"},  wd_w,  d);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mw"},  {30'b0, mw, mw_w}, 32'd0);
    chk({tag, ".adr"}, adr | adr_w, 32'd0);
    chk({tag, ".wd"},  wd | wd_w, 32'd0);
    chk_ctl(tag, 5'b00100);
  endtask

  // One load session from IDLE/RUN/ERROR; expectations derived from len, the valid pattern and the word list.
  task automatic session(input int L, input bit tr_good, input bit rand_start);
    int k = 0;
    int cyc = 0;
    logic [31:0] sum = '0;
    logic [31:0] trailer;
    start = 1'b1; len = L[15:0]; in_valid = 1'b0;
    step();
    start = 1'b0;
    if (L > 64) begin
      chk_ctl("lenerr", 5'b00101);
      chk_wr("lenerr", 1'b0, 1'b0, '0, '0);
      repeat (3) begin
        in_valid = 1'b1; in_data = $urandom;
        step();
        chk_wr("lenerr.nowr", 1'b0, 1'b0, '0, '0);
        chk_ctl("lenerr.hold", 5'b00101);
      end
      in_valid = 1'b0;
      return;
    end
    if (L == 0) begin
      chk_ctl("len0.done", 5'b01110);
      step();
      chk_ctl("len0.run", 5'b00000);
      return;
    end
    chk_ctl("start", 5'b10110);
    while (k < L) begin
      bit v;
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = ($urandom_range(0, 3) != 0) || (cyc > 1000);
      in_valid = v;
      in_data  = v ? words[k] : $urandom;
      if (rand_start) begin
        start = $urandom_range(0, 1) == 1;
        len   = 16'($urandom);
      end
      step();
      cyc++;
      start = 1'b0;
      chk_wr("load", v, 1'b0, 32'(4 * k), words[k]);
      if (v) begin
        sum = sum + words[k];
        k++;
      end
`ifdef T1C_LOADER_CHECKSUM_EN
      chk_ctl("load", 5'b10110);
`else
      chk_ctl(k == L ? "last" : "load", k == L ? 5'b01110 : 5'b10110);
`endif
    end
    trailer = tr_good ? sum : sum + 32'd1;
`ifdef T1C_LOADER_CHECKSUM_EN
    in_valid = 1'b0;
    step();
    chk_wr("chkwait", 1'b0, 1'b1, 32'(4 * (L - 1)), words[L-1]);
    chk_ctl("chkwait", 5'b10110);
    in_valid = 1'b1; in_data = trailer;
    step();
    in_valid = 1'b0;
    chk_wr("trailer", 1'b0, 1'b1, 32'(4 * (L - 1)), words[L-1]);
    if (tr_good) begin
      chk_ctl("trail_ok", 5'b01110);
      step();
      chk_ctl("trail_ok.run", 5'b00000);
    end else begin
      chk_ctl("trail_bad", 5'b00101);
      step();
      chk_ctl("trail_bad.hold", 5'b00101);
    end
`else
    in_valid = 1'b1; in_data = trailer;
    step();
    chk_wr("run", 1'b0, 1'b1, 32'(4 * (L - 1)), words[L-1]);
    chk_ctl("run", 5'b00000);
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    #1;
    reset = 1'b1;
    step(); step();
    chk_reset("reset");
    reset = 1'b0;
    step();
    chk_reset("idle");

    tbl.push_back('{1'b1, 16'd3, 1'b0, 32'h0,         1'b0, 1'b0, 32'd0, 32'h0,         5'b10110});
    tbl.push_back('{1'b0, 16'd0, 1'b1, 32'h00500113, 1'b1, 1'b0, 32'd0, 32'h00500113, 5'b10110});
    tbl.push_back('{1'b0, 16'd0, 1'b1, 32'h00C00193, 1'b1, 1'b0, 32'd4, 32'h00C00193, 5'b10110});
`ifdef T1C_LOADER_CHECKSUM_EN
    tbl.push_back('{1'b0, 16'd0, 1'b1, 32'hFF718393, 1'b1, 1'b0, 32'd8, 32'hFF718393, 5'b10110});
    tbl.push_back('{1'b0, 16'd0, 1'b1, 32'h00818639, 1'b0, 1'b1, 32'd8, 32'hFF718393, 5'b01110});
    tbl.push_back('{1'b0, 16'd0, 1'b0, 32'h0,         1'b0, 1'b1, 32'd8, 32'hFF718393, 5'b00000});
`else
    tbl.push_back('{1'b0, 16'd0, 1'b1, 32'hFF718393, 1'b1, 1'b0, 32'd8, 32'hFF718393, 5'b01110});
    tbl.push_back('{1'b0, 16'd0, 1'b0, 32'h0,         1'b0, 1'b1, 32'd8, 32'hFF718393, 5'b00000});
`endif
    foreach (tbl[i]) begin
      start = tbl[i].st; len = tbl[i].ln; in_valid = tbl[i].v; in_data = tbl[i].d;
      step();
      chk_wr($sformatf("tbl%0d", i), tbl[i].mw, tbl[i].hold, tbl[i].off, tbl[i].wdat);
      chk_ctl($sformatf("tbl%0d", i), tbl[i].ctl);
    end
    start = 1'b0; in_valid = 1'b0;

    // len=2 with gaps in in_valid
    words = '{32'hDEAD_0001, 32'hDEAD_0002};
    vpat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    session(2, 1'b1, 1'b0);

    // reset after first of four words
    start = 1'b1; len = 16'd4;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0001;
    step();
    chk_wr("rst.w0", 1'b1, 1'b0, 32'd0, 32'hA5A5_0001);
    in_data = 32'hA5A5_0002; reset = 1'b1;
    step();
    chk_reset("rst.mid");
    reset = 1'b0;
    repeat (3) begin
      step();
      chk_wr("rst.nowr", 1'b0, 1'b0, '0, '0);
    end
    in_valid = 1'b0;
    words = '{32'h1234_5678};
    session(1, 1'b1, 1'b0);

    // over-length request, then recovery; exactly DEPTH accepted
    session(65, 1'b1, 1'b0);
    words = '{32'h0BAD_F00D};
    session(1, 1'b1, 1'b0);
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back($urandom);
    session(64, 1'b1, 1'b0);

    // checksum trailer good and bad with words 1,2,3
    words = '{32'd1, 32'd2, 32'd3};
    session(3, 1'b1, 1'b0);
    session(3, 1'b0, 1'b0);
    session(0, 1'b1, 1'b0);

    for (int s = 0; s < 30; s++) begin
      int L;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      L = 0;
      else if (sel == 1) L = int'($urandom_range(65, 70));
      else if (sel == 2) L = 64;
      else               L = int'($urandom_range(1, 8));
      words.delete();
      for (int i = 0; i < L; i++) words.push_back($urandom);
      session(L, $urandom_range(0, 1) == 1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
